// File: rtl/debug_rf_dump_if.sv
// Debug-dump bus: start/status handshake, register-file debug read port and
// the {index, data} output stream toward the debug transport.
// master = dump engine, slave = the surrounding system / transport.
`timescale 1ns/1ps
interface debug_rf_dump_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [4:0]  rf_ra;
   logic [31:0] rf_rd;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_index;
   logic [31:0] out_data;
   logic        out_last;

   modport master (
      input  start, rf_rd, out_ready,
      output busy, done, rf_ra, out_valid, out_index, out_data, out_last
   );

   modport slave (
      output start, rf_rd, out_ready,
      input  busy, done, rf_ra, out_valid, out_index, out_data, out_last
   );
endinterface

// File: rtl/debug_rf_dump.sv
// Register-file dump engine. On start it walks rf_ra over 0..NUM_REGS-1,
// waits SETTLE_CYCLES per index, captures rf_rd and offers each {index, data}
// word on a valid/ready stream. Optional feature macro: DEBUG_DUMP_CHECKSUM_EN
// appends a final XOR-checksum word (index 0) that carries out_last.
`timescale 1ns/1ps
module debug_rf_dump #(
   parameter int NUM_REGS      = 32,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   debug_rf_dump_if.master bus
);

   localparam logic [4:0] LAST_IDX    = 5'(NUM_REGS - 1);
   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

`ifdef DEBUG_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SEND, S_CSUM, S_FINISH} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SEND, S_FINISH} state_t;
`endif

   state_t      state_q, state_d;
   logic [4:0]  index_q, index_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [4:0]  out_index_q, out_index_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;
`endif

   // Next-state and datapath updates; every _d defaults to hold.
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      cnt_d       = cnt_q;
      out_index_d = out_index_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SETTLE;
               index_d = 5'd0;
               cnt_d   = 3'd0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
               csum_d  = 32'd0;
`endif
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               out_data_d  = bus.rf_rd;
               out_index_d = index_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
               out_last_d  = 1'b0;
`else
               out_last_d  = (index_q == LAST_IDX);
`endif
               state_d     = S_SEND;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_SEND: begin
            if (bus.out_ready) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
               csum_d = csum_q ^ out_data_q;
`endif
               if (index_q < LAST_IDX) begin
                  // Index stops at LAST_IDX, so it never wraps.
                  index_d = index_q + 5'd1;
                  cnt_d   = 3'd0;
                  state_d = S_SETTLE;
               end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                  // Load the checksum word directly so CSUM needs no extra mux.
                  out_data_d  = csum_q ^ out_data_q;
                  out_index_d = 5'd0;
                  out_last_d  = 1'b1;
                  state_d     = S_CSUM;
`else
                  state_d     = S_FINISH;
`endif
               end
            end
         end
`ifdef DEBUG_DUMP_CHECKSUM_EN
         S_CSUM: begin
            if (bus.out_ready) state_d = S_FINISH;
         end
`endif
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any dump in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         index_q     <= 5'd0;
         cnt_q       <= 3'd0;
         out_index_q <= 5'd0;
         out_data_q  <= 32'd0;
         out_last_q  <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
         csum_q      <= 32'd0;
`endif
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         cnt_q       <= cnt_d;
         out_index_q <= out_index_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_FINISH);
   assign bus.rf_ra     = (state_q == S_SETTLE || state_q == S_SEND) ? index_q : 5'd0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
   assign bus.out_valid = (state_q == S_SEND) || (state_q == S_CSUM);
`else
   assign bus.out_valid = (state_q == S_SEND);
`endif
   assign bus.out_index = out_index_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

endmodule
